// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the 8-bit bus CPU control path.
// Holds the control-word bit indices and their one-hot masks, the opcode
// encodings and the T-state encodings used by the sequencer and its ROM.
package cpu_ctrl_pkg;

    localparam int unsigned CTRL_W = 16;
    localparam int unsigned STEP_W = 3;

    // Control-word bit indices
    localparam int unsigned IDX_HLT = 15;
    localparam int unsigned IDX_MI  = 14;
    localparam int unsigned IDX_RI  = 13;
    localparam int unsigned IDX_RO  = 12;
    localparam int unsigned IDX_IO  = 11;
    localparam int unsigned IDX_II  = 10;
    localparam int unsigned IDX_AI  = 9;
    localparam int unsigned IDX_AO  = 8;
    localparam int unsigned IDX_EO  = 7;
    localparam int unsigned IDX_SU  = 6;
    localparam int unsigned IDX_BI  = 5;
    localparam int unsigned IDX_OI  = 4;
    localparam int unsigned IDX_CE  = 3;
    localparam int unsigned IDX_CO  = 2;
    localparam int unsigned IDX_JMP = 1;
    localparam int unsigned IDX_FI  = 0;

    // Single-bit masks derived from the indices
    localparam logic [CTRL_W-1:0] CTRL_HLT = 16'h1 << IDX_HLT;
    localparam logic [CTRL_W-1:0] CTRL_MI  = 16'h1 << IDX_MI;
    localparam logic [CTRL_W-1:0] CTRL_RI  = 16'h1 << IDX_RI;
    localparam logic [CTRL_W-1:0] CTRL_RO  = 16'h1 << IDX_RO;
    localparam logic [CTRL_W-1:0] CTRL_IO  = 16'h1 << IDX_IO;
    localparam logic [CTRL_W-1:0] CTRL_II  = 16'h1 << IDX_II;
    localparam logic [CTRL_W-1:0] CTRL_AI  = 16'h1 << IDX_AI;
    localparam logic [CTRL_W-1:0] CTRL_AO  = 16'h1 << IDX_AO;
    localparam logic [CTRL_W-1:0] CTRL_EO  = 16'h1 << IDX_EO;
    localparam logic [CTRL_W-1:0] CTRL_SU  = 16'h1 << IDX_SU;
    localparam logic [CTRL_W-1:0] CTRL_BI  = 16'h1 << IDX_BI;
    localparam logic [CTRL_W-1:0] CTRL_OI  = 16'h1 << IDX_OI;
    localparam logic [CTRL_W-1:0] CTRL_CE  = 16'h1 << IDX_CE;
    localparam logic [CTRL_W-1:0] CTRL_CO  = 16'h1 << IDX_CO;
    localparam logic [CTRL_W-1:0] CTRL_JMP = 16'h1 << IDX_JMP;
    localparam logic [CTRL_W-1:0] CTRL_FI  = 16'h1 << IDX_FI;

    // Opcodes (IR upper nibble); 9..D are undefined and fetch-only
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // T-states
    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the sequencer and the datapath.
//   opcode, flag_c, flag_z : IR nibble and latched ALU flags into the sequencer
//   ctrl                   : control word fanned out to every bus client
//   step, halted           : debug T-state and halt latch
// master = sequencer side, slave = datapath side.
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic [3:0]        opcode;
    logic              flag_c;
    logic              flag_z;
    logic [CTRL_W-1:0] ctrl;
    logic [STEP_W-1:0] step;
    logic              halted;

    modport master (
        input  opcode,
        input  flag_c,
        input  flag_z,
        output ctrl,
        output step,
        output halted
    );

    modport slave (
        output opcode,
        output flag_c,
        output flag_z,
        input  ctrl,
        input  step,
        input  halted
    );

endinterface

// File: rtl/microcode_rom.sv
// Purely combinational microcode decode.
//   opcode_i, step_i, flag_c_i, flag_z_i : decode address
//   ctrl_o      : control word for this step (0 for steps an opcode does not use)
//   last_step_o : this is the instruction's last active step
module microcode_rom
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0]        opcode_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              flag_c_i,
    input  logic              flag_z_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              last_step_o
);

    always_comb begin
        ctrl_o      = '0;
        last_step_o = 1'b0;
        case (step_i)
            T0: ctrl_o = CTRL_CO | CTRL_MI;
            T1: begin
                ctrl_o = CTRL_RO | CTRL_II | CTRL_CE;
                // Fetch-only opcodes and not-taken branches finish here
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA,
                    OP_LDI, OP_JMP, OP_OUT, OP_HLT: last_step_o = 1'b0;
                    OP_JC:   last_step_o = ~flag_c_i;
                    OP_JZ:   last_step_o = ~flag_z_i;
                    default: last_step_o = 1'b1;
                endcase
            end
            T2: begin
                last_step_o = 1'b1;
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl_o      = CTRL_IO | CTRL_MI;
                        last_step_o = 1'b0;
                    end
                    OP_LDI:  ctrl_o = CTRL_IO | CTRL_AI;
                    OP_JMP:  ctrl_o = CTRL_IO | CTRL_JMP;
                    OP_JC:   ctrl_o = flag_c_i ? (CTRL_IO | CTRL_JMP) : '0;
                    OP_JZ:   ctrl_o = flag_z_i ? (CTRL_IO | CTRL_JMP) : '0;
                    OP_OUT:  ctrl_o = CTRL_AO | CTRL_OI;
                    OP_HLT:  ctrl_o = CTRL_HLT;
                    default: ctrl_o = '0;
                endcase
            end
            T3: begin
                last_step_o = 1'b1;
                case (opcode_i)
                    OP_LDA: ctrl_o = CTRL_RO | CTRL_AI;
                    OP_ADD, OP_SUB: begin
                        ctrl_o      = CTRL_RO | CTRL_BI;
                        last_step_o = 1'b0;
                    end
                    OP_STA:  ctrl_o = CTRL_AO | CTRL_RI;
                    default: ctrl_o = '0;
                endcase
            end
            T4: begin
                last_step_o = 1'b1;
                case (opcode_i)
                    OP_ADD:  ctrl_o = CTRL_EO | CTRL_AI | CTRL_FI;
                    OP_SUB:  ctrl_o = CTRL_EO | CTRL_AI | CTRL_FI | CTRL_SU;
                    default: ctrl_o = '0;
                endcase
            end
            default: last_step_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: owns the T-state counter and the halt latch and
// drives the control word for every bus client.
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : master side of control_sequencer_if (opcode/flags in,
//            ctrl/step/halted out)
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned NSTEPS    = 5,
    parameter bit          EARLY_END = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_sequencer_if.master  bus
);

    logic [STEP_W-1:0] step_q, step_d;
    logic              halted_q, halted_d;
    logic [CTRL_W-1:0] rom_ctrl;
    logic              rom_last;
    logic              wrap;

    microcode_rom u_rom (
        .opcode_i    (bus.opcode),
        .step_i      (step_q),
        .flag_c_i    (bus.flag_c),
        .flag_z_i    (bus.flag_z),
        .ctrl_o      (rom_ctrl),
        .last_step_o (rom_last)
    );

    // The NSTEPS-1 bound also guards early-end mode against a runaway count.
    always_comb begin
        wrap = (step_q == STEP_W'(NSTEPS - 1));
        if (EARLY_END) begin
            wrap = wrap | rom_last;
        end
    end

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            // HLT's only active word is at T2, so seeing it means halt now
            if (rom_ctrl[IDX_HLT]) begin
                halted_d = 1'b1;
                step_d   = T0;
            end else if (wrap) begin
                step_d = T0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    assign bus.ctrl   = halted_q ? CTRL_HLT : rom_ctrl;
    assign bus.step   = step_q;
    assign bus.halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: EARLY_END=1 instance, index 1: EARLY_END=0 instance
    logic       rst_v [2];
    logic [3:0] op_v  [2];
    logic       fc_v  [2];
    logic       fz_v  [2];
    bit         rnd_v [2];

    control_sequencer_if bus_a ();
    control_sequencer_if bus_b ();

    assign bus_a.opcode = op_v[0];
    assign bus_a.flag_c = fc_v[0];
    assign bus_a.flag_z = fz_v[0];
    assign bus_b.opcode = op_v[1];
    assign bus_b.flag_c = fc_v[1];
    assign bus_b.flag_z = fz_v[1];

    control_sequencer #(.NSTEPS(5), .EARLY_END(1'b1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_v[0]),
        .bus   (bus_a)
    );

    control_sequencer #(.NSTEPS(5), .EARLY_END(1'b0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_v[1]),
        .bus   (bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: position inside the instruction and halt latch
    int m_idx  [2];
    bit m_halt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole instruction as a list of control words: common fetch, then the
    // execute words; padded with zeros to 5 slots when early end is off.
    function automatic void build(input logic [3:0] op, input logic c, input logic z,
                                  input bit early, output logic [4:0][15:0] w,
                                  output int len);
        logic [15:0] ex[$];
        ex = {};
        case (op)
            4'h1: ex = {16'h4800, 16'h1200};
            4'h2: ex = {16'h4800, 16'h1020, 16'h0281};
            4'h3: ex = {16'h4800, 16'h1020, 16'h02C1};
            4'h4: ex = {16'h4800, 16'h2100};
            4'h5: ex = {16'h0A00};
            4'h6: ex = {16'h0802};
            4'h7: if (c) ex = {16'h0802};
            4'h8: if (z) ex = {16'h0802};
            4'hE: ex = {16'h0110};
            4'hF: ex = {16'h8000};
            default: ex = {};
        endcase
        w = '0;
        w[0] = 16'h4004;
        w[1] = 16'h1408;
        for (int i = 0; i < ex.size(); i++) w[2+i] = ex[i];
        len = early ? 2 + ex.size() : 5;
    endfunction

    task automatic check_dut(input int d, input string tag);
        logic [4:0][15:0] w;
        int               len;
        logic [15:0]      got_ctrl;
        logic [2:0]       got_step;
        logic             got_halt;
        logic [15:0]      exp_ctrl;
        build(op_v[d], fc_v[d], fz_v[d], d == 0, w, len);
        got_ctrl = (d == 0) ? bus_a.ctrl   : bus_b.ctrl;
        got_step = (d == 0) ? bus_a.step   : bus_b.step;
        got_halt = (d == 0) ? bus_a.halted : bus_b.halted;
        exp_ctrl = m_halt[d] ? 16'h8000 : w[m_idx[d]];
        check($sformatf("%s.d%0d.ctrl", tag, d), 32'(got_ctrl), 32'(exp_ctrl));
        check($sformatf("%s.d%0d.step", tag, d), 32'(got_step),
              m_halt[d] ? 32'd0 : 32'(m_idx[d]));
        check($sformatf("%s.d%0d.halted", tag, d), 32'(got_halt), 32'(m_halt[d]));
        // Bus drivers CO, RO, IO, AO, EO: at most one at a time
        check($sformatf("%s.d%0d.one_driver", tag, d),
              32'($countones(got_ctrl & 16'h1984) <= 1), 32'd1);
        check($sformatf("%s.d%0d.ce_jmp_excl", tag, d),
              32'((got_ctrl & 16'h000A) != 16'h000A), 32'd1);
    endtask

    task automatic model_edge();
        logic [4:0][15:0] w;
        int               len;
        for (int d = 0; d < 2; d++) begin
            if (!rst_v[d]) begin
                m_idx[d]  = 0;
                m_halt[d] = 1'b0;
            end else if (!m_halt[d]) begin
                build(op_v[d], fc_v[d], fz_v[d], d == 0, w, len);
                if (op_v[d] == 4'hF && m_idx[d] == 2) begin
                    m_halt[d] = 1'b1;
                    m_idx[d]  = 0;
                end else if (m_idx[d] + 1 >= len) begin
                    m_idx[d] = 0;
                end else begin
                    m_idx[d] = m_idx[d] + 1;
                end
            end
        end
    endtask

    // One clock: optional random stimulus, check both DUTs mid-cycle, advance model.
    task automatic cycle(input string tag);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rnd_v[d]) begin
                rst_v[d] = 1'b1;
                if (m_halt[d]) begin
                    op_v[d] = 4'($urandom);
                    if ($urandom_range(0, 3) == 0) rst_v[d] = 1'b0;
                end else begin
                    if (m_idx[d] == 0) begin
                        op_v[d] = 4'($urandom);
                        fc_v[d] = 1'($urandom);
                        fz_v[d] = 1'($urandom);
                    end
                    if ($urandom_range(0, 63) == 0) rst_v[d] = 1'b0;
                end
            end
        end
        #1;
        check_dut(0, tag);
        check_dut(1, tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d]  = 1'b0;
            op_v[d]   = 4'h5;
            fc_v[d]   = 1'b0;
            fz_v[d]   = 1'b0;
            rnd_v[d]  = 1'b0;
            m_idx[d]  = 0;
            m_halt[d] = 1'b0;
        end
        @(posedge clk);
        model_edge();
        #1;
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;

        // LDI on both instances: 3-cycle vs 5-cycle period
        run(6, "ldi");
        op_v[0] = 4'h3;
        run(10, "sub");
        op_v[0] = 4'h7; fc_v[0] = 1'b0;
        run(4, "jc_nt");
        fc_v[0] = 1'b1;
        run(6, "jc_t");
        op_v[0] = 4'h8; fz_v[0] = 1'b1;
        run(3, "jz_t");
        fz_v[0] = 1'b0;
        run(2, "jz_nt");

        // Reset during ADD's T3: no FI may ever appear
        op_v[0] = 4'h2;
        run(3, "add_pre");
        rst_v[0] = 1'b0;
        run(1, "add_rst");
        rst_v[0] = 1'b1;
        op_v[0] = 4'h0;
        run(2, "add_post");

        // Halt, ignore opcode changes, release by reset
        op_v[0] = 4'hF;
        run(3, "hlt");
        for (int i = 0; i < 12; i++) begin
            op_v[0] = 4'($urandom);
            cycle("halted");
        end
        rst_v[0] = 1'b0;
        run(1, "hlt_rst");
        rst_v[0] = 1'b1;
        op_v[0] = 4'h5;
        run(3, "after_hlt");

        // Random instruction stream on both instances
        rnd_v[0] = 1'b1;
        rnd_v[1] = 1'b1;
        run(600, "rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
